// File: rtl/conv_frame_ctrl_pkg.sv
// Shared definitions for the convolution frame sequencer, the line buffer
// and the top-level control.
//   CONV_KERNEL_SIZE : window edge length (only 3 is supported)
//   frame_state_e    : frame sequencer state encoding
package conv_frame_ctrl_pkg;

  localparam int CONV_KERNEL_SIZE = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } frame_state_e;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster position counter (row/column) for pixels entering the line buffer.
//   clk, rstb : clock, async active-low reset
//   clr_i     : synchronous clear to (0,0), wins over en_i
//   en_i      : advance one position in raster order
//   row_o     : current row
//   col_o     : current column
//   last_o    : position is the final pixel of the frame
module conv_pos_counter #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             last_o
);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             col_wrap;

  assign col_wrap = (col_q == CNT_W'(WIDTH - 1));
  assign last_o   = col_wrap && (row_q == CNT_W'(HEIGHT - 1));
  assign row_o    = row_q;
  assign col_o    = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 convolution line buffer. Streams one
// WIDTH x HEIGHT frame from image memory into the buffer, honouring buffer
// stalls, and flags each cycle in which a full window is available.
//   clk, rstb   : clock, async active-low reset
//   start       : one-cycle frame request, ignored unless idle
//   buf_ready   : line buffer accepts a pixel this cycle
//   mem_rd_en   : image-memory read strobe (1-cycle read latency)
//   mem_rd_addr : raster read address
//   pix_valid   : memory data valid toward the buffer
//   win_valid   : one-cycle pulse, new window at (win_row, win_col)
//   res_addr    : result-memory address of the current window
//   busy, done  : frame in progress / end-of-frame pulse
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | issuing reads
// ST_DRAIN | last read issued, waiting for the last pixel to be accepted
// ST_DONE  | one cycle before returning to idle
module conv_frame_ctrl
  import conv_frame_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              buf_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              pix_valid,
  output logic              win_valid,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  localparam int                RC_W      = 5;
  localparam int                EDGE      = KERNEL_SIZE - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  frame_state_e      state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic              win_valid_q, win_valid_d;
  logic [RC_W-1:0]   win_row_q, win_row_d;
  logic [RC_W-1:0]   win_col_q, win_col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_ok;
  logic              accept;
  logic              win_hit;
  logic [RC_W-1:0]   p_row, p_col;
  logic              p_last;

  // The done pulse cycle is still treated as part of the frame, so a new
  // start is only taken once done has dropped.
  assign start_ok  = start && (state_q == ST_IDLE) && !done_q;
  assign accept    = pix_valid_q && buf_ready;
  assign win_hit   = accept && (p_row >= RC_W'(EDGE)) && (p_col >= RC_W'(EDGE));
  // A stalled pixel blocks the next read so the memory output is held.
  assign mem_rd_en = (state_q == ST_RUN) && (!pix_valid_q || buf_ready);

  conv_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CNT_W  (RC_W)
  ) u_pos (
    .clk    (clk),
    .rstb   (rstb),
    .clr_i  (start_ok),
    .en_i   (accept),
    .row_o  (p_row),
    .col_o  (p_col),
    .last_o (p_last)
  );

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    res_addr_d  = res_addr_q;
    pix_valid_d = pix_valid_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    unique case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (mem_rd_en && (rd_addr_q == LAST_ADDR)) state_d = ST_DRAIN;
      ST_DRAIN: if (accept && p_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (mem_rd_en) begin
      rd_addr_d   = rd_addr_q + ADDR_W'(1);
      pix_valid_d = 1'b1;
    end else if (buf_ready) begin
      pix_valid_d = 1'b0;
    end

    if (win_hit) begin
      win_valid_d = 1'b1;
      win_row_d   = p_row - RC_W'(EDGE);
      win_col_d   = p_col - RC_W'(EDGE);
    end

    // Result address is the running window count; it moves on after each
    // pulse so it reads row*(WIDTH-2)+col during the pulse itself.
    if (win_valid_q) res_addr_d = res_addr_q + ADDR_W'(1);

    if (start_ok) begin
      rd_addr_d  = '0;
      res_addr_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      res_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      res_addr_q  <= res_addr_d;
      pix_valid_q <= pix_valid_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_addr = rd_addr_q;
  assign res_addr    = res_addr_q;
  assign pix_valid   = pix_valid_q;
  assign win_valid   = win_valid_q;
  assign win_row     = win_row_q;
  assign win_col     = win_col_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with default parameters (32x32 frame).
// An identity image memory (data = address) lets every accepted pixel be
// checked against its expected raster index.
module tb_conv_frame_ctrl;
  import conv_frame_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       start = 1'b0;
  logic       buf_ready = 1'b1;
  logic       mem_rd_en;
  logic [9:0] mem_rd_addr;
  logic       pix_valid;
  logic       win_valid;
  logic [4:0] win_row;
  logic [4:0] win_col;
  logic [9:0] res_addr;
  logic       busy;
  logic       done;
  logic [9:0] mem_data;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int cyc0 = 0;
  bit mon_en = 1'b0;

  int n_reads, rd_err, n_acc, acc_err, n_win, n_exp, win_err;
  int first_win_cyc, last_win_cyc, done_cnt, done_cyc, busy_err;
  int stall_cnt, stall_err, stall_pix, prev_acc, rel, r, c;
  int pend_r, pend_c, pend_res;
  bit pend_win;
  logic [9:0] first_rc, last_rc, first_res, last_res;
  bit         win_flag_after [1024];
  logic [9:0] win_rc_after   [1024];

  conv_frame_ctrl dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .buf_ready   (buf_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .pix_valid   (pix_valid),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .res_addr    (res_addr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en === 1'b1) mem_data <= mem_rd_addr;

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - cyc0;
      if (prev_acc >= 0) begin
        win_flag_after[prev_acc] = win_valid;
        win_rc_after[prev_acc]   = {win_row, win_col};
      end
      prev_acc = -1;
      if (win_valid !== pend_win) win_err++;
      else if (pend_win && (win_row !== pend_r[4:0] || win_col !== pend_c[4:0] ||
                            res_addr !== pend_res[9:0])) win_err++;
      if (win_valid === 1'b1) begin
        if (n_win == 0) begin
          first_win_cyc = rel;
          first_rc      = {win_row, win_col};
          first_res     = res_addr;
        end
        last_win_cyc = rel;
        last_rc      = {win_row, win_col};
        last_res     = res_addr;
        n_win++;
      end
      pend_win = 1'b0;
      if (mem_rd_en === 1'b1) begin
        if (mem_rd_addr !== n_reads[9:0]) rd_err++;
        n_reads++;
      end
      if (pix_valid === 1'b1 && buf_ready === 1'b1) begin
        if (mem_data !== n_acc[9:0]) acc_err++;
        r = n_acc / 32;
        c = n_acc % 32;
        if (r >= 2 && c >= 2) begin
          pend_win = 1'b1;
          pend_r   = r - 2;
          pend_c   = c - 2;
          pend_res = n_exp;
          n_exp++;
        end
        if (n_acc < 1024) prev_acc = n_acc;
        n_acc++;
      end
      if (pix_valid === 1'b1 && buf_ready === 1'b0) begin
        if (mem_rd_en !== 1'b0) stall_err++;
        else begin
          stall_cnt++;
          stall_pix = n_acc;
        end
      end
      if (rel == 0 && busy !== 1'b0) busy_err++;
      if (rel >= 1 && done_cnt == 0 && done !== 1'b1 && busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_err++;
        done_cnt++;
        done_cyc = rel;
      end
    end
  end

  task automatic clear_mon();
    n_reads = 0; rd_err = 0; n_acc = 0; acc_err = 0; n_win = 0; n_exp = 0;
    win_err = 0; first_win_cyc = -1; last_win_cyc = -1; done_cnt = 0;
    done_cyc = -1; busy_err = 0; stall_cnt = 0; stall_err = 0; stall_pix = -1;
    prev_acc = -1; pend_win = 1'b0; first_rc = '1; last_rc = '1;
    first_res = '1; last_res = '1;
    for (int i = 0; i < 1024; i++) begin
      win_flag_after[i] = 1'b0;
      win_rc_after[i]   = '1;
    end
  endtask

  // mode 0: plain (start re-pulsed in cycle 1027), 1: 5-cycle stall at
  // pixel 40, 2: start re-pulsed in cycles 10 and 500, 3: random
  // buf_ready, 4: stop once 300 pixels are accepted.
  task automatic run_frame(input int mode, input int timeout);
    int k;
    clear_mon();
    @(posedge clk); #1;
    cyc0      = cyc;
    mon_en    = 1'b1;
    start     = 1'b1;
    buf_ready = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    k = 0;
    @(negedge clk); #1;
    while (done_cnt == 0 && k < timeout && !(mode == 4 && n_acc >= 300)) begin
      @(posedge clk); #1;
      k++;
      start = ((mode == 2) && (k == 10 || k == 500)) || ((mode == 0) && (k == 1027));
      case (mode)
        1:       buf_ready = !(k >= 42 && k <= 46);
        3:       buf_ready = 1'($urandom_range(0, 1));
        default: buf_ready = 1'b1;
      endcase
      @(negedge clk); #1;
    end
    mon_en = 1'b0;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    start = 1'b0;
    buf_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  task automatic tail_idle(input string name);
    start = 1'b0;
    buf_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fails++;
      $display("FAIL %s_idle_after_done: busy,done=%b required 00", name, {busy, done});
    end
  endtask

  task automatic test_reset();
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_rd_en, mem_rd_addr, pix_valid, win_valid, win_row, win_col, res_addr, busy, done} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: rd_en=%b addr=%0d pv=%b wv=%b row=%0d col=%0d res=%0d busy=%b done=%b required all 0",
               mem_rd_en, mem_rd_addr, pix_valid, win_valid, win_row, win_col, res_addr, busy, done);
    end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fails++;
      $display("FAIL reset_state: got %0d required %0d", dut.state_q, ST_IDLE);
    end
    @(posedge clk); #1 rstb = 1'b1;
  endtask

  task automatic check_frame(input string name, input int exp_done);
    n_checks++;
    if (n_reads !== 1024 || rd_err !== 0) begin
      n_fails++;
      $display("FAIL %s_reads: count=%0d order_errors=%0d required 1024/0", name, n_reads, rd_err);
    end
    n_checks++;
    if (n_acc !== 1024 || acc_err !== 0) begin
      n_fails++;
      $display("FAIL %s_accepts: count=%0d data_errors=%0d required 1024/0", name, n_acc, acc_err);
    end
    n_checks++;
    if (n_win !== 900 || win_err !== 0) begin
      n_fails++;
      $display("FAIL %s_windows: count=%0d window_errors=%0d required 900/0", name, n_win, win_err);
    end
    n_checks++;
    if (done_cnt !== 1 || busy_err !== 0) begin
      n_fails++;
      $display("FAIL %s_done_busy: done_count=%0d busy_errors=%0d required 1/0", name, done_cnt, busy_err);
    end
    if (exp_done >= 0) begin
      n_checks++;
      if (done_cyc !== exp_done) begin
        n_fails++;
        $display("FAIL %s_done_cycle: got %0d required %0d", name, done_cyc, exp_done);
      end
    end
  endtask

  task automatic test_full_frame();
    run_frame(0, 3000);
    start = 1'b0;
    check_frame("full", 1027);
    n_checks++;
    if (first_win_cyc !== 69 || first_rc !== 10'd0 || first_res !== 10'd0) begin
      n_fails++;
      $display("FAIL full_first_window: cycle=%0d rc=%h res=%0d required 69/000/0", first_win_cyc, first_rc, first_res);
    end
    n_checks++;
    if (last_win_cyc !== 1026 || last_rc !== {5'd29, 5'd29} || last_res !== 10'd899) begin
      n_fails++;
      $display("FAIL full_last_window: cycle=%0d rc=%h res=%0d required 1026/3bd/899", last_win_cyc, last_rc, last_res);
    end
    tail_idle("full");
  endtask

  task automatic test_row_wrap();
    run_frame(0, 3000);
    start = 1'b0;
    n_checks++;
    if (win_flag_after[95] !== 1'b1 || win_rc_after[95] !== {5'd0, 5'd29}) begin
      n_fails++;
      $display("FAIL wrap_after_2_31: wv=%b rc=%h required 1/01d", win_flag_after[95], win_rc_after[95]);
    end
    n_checks++;
    if (win_flag_after[96] !== 1'b0 || win_flag_after[97] !== 1'b0) begin
      n_fails++;
      $display("FAIL wrap_after_3_0_3_1: wv=%b%b required 00", win_flag_after[96], win_flag_after[97]);
    end
    n_checks++;
    if (win_flag_after[98] !== 1'b1 || win_rc_after[98] !== {5'd1, 5'd0}) begin
      n_fails++;
      $display("FAIL wrap_after_3_2: wv=%b rc=%h required 1/020", win_flag_after[98], win_rc_after[98]);
    end
    tail_idle("wrap");
  endtask

  task automatic test_stall();
    run_frame(1, 3000);
    check_frame("stall", 1032);
    n_checks++;
    if (stall_cnt !== 5 || stall_err !== 0 || stall_pix !== 40) begin
      n_fails++;
      $display("FAIL stall_hold: stalled_cycles=%0d read_during_stall=%0d pixel=%0d required 5/0/40", stall_cnt, stall_err, stall_pix);
    end
    tail_idle("stall");
  endtask

  task automatic test_start_ignored();
    run_frame(2, 3000);
    check_frame("restart", 1027);
    tail_idle("restart");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 3000);
    // start held high across cycles 1027 (done pulse) and 1028
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_start_in_done_cycle: busy=%b required 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_rd_addr !== 10'd0) begin
      n_fails++;
      $display("FAIL b2b_restart: busy=%b rd_en=%b addr=%0d required 1/1/0", busy, mem_rd_en, mem_rd_addr);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    run_frame(4, 3000);
    n_checks++;
    if (n_acc !== 300) begin
      n_fails++;
      $display("FAIL midreset_reach_300: accepted=%0d required 300", n_acc);
    end
    rstb = 1'b0;
    #1;
    n_checks++;
    if ({mem_rd_en, mem_rd_addr, pix_valid, win_valid, win_row, win_col, res_addr, busy, done} !== '0) begin
      n_fails++;
      $display("FAIL midreset_outputs: rd_en=%b addr=%0d pv=%b wv=%b row=%0d col=%0d res=%0d busy=%b done=%b required all 0",
               mem_rd_en, mem_rd_addr, pix_valid, win_valid, win_row, win_col, res_addr, busy, done);
    end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fails++;
      $display("FAIL midreset_state: got %0d required %0d", dut.state_q, ST_IDLE);
    end
    @(posedge clk); #1 rstb = 1'b1;
    run_frame(0, 3000);
    start = 1'b0;
    check_frame("after_reset", 1027);
    tail_idle("after_reset");
  endtask

  task automatic test_random_ready();
    run_frame(3, 6000);
    check_frame("random", -1);
    n_checks++;
    if (stall_err !== 0) begin
      n_fails++;
      $display("FAIL random_read_during_stall: count=%0d required 0", stall_err);
    end
    n_checks++;
    if (first_res !== 10'd0 || last_res !== 10'd899) begin
      n_fails++;
      $display("FAIL random_res_range: first=%0d last=%0d required 0/899", first_res, last_res);
    end
    tail_idle("random");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_row_wrap();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the 3x3 convolution line buffer. On a start pulse it streams one WIDTH x HEIGHT RGB frame from the image memory into the line buffer, honouring the buffer's ready/stall. It tracks the pixel position and flags each cycle in which a complete 3x3 window is available, giving the window's coordinate and its result-memory address. It sits between the top-level control FSM and the buffer/convolution datapath.

## Interface
- WIDTH, 32, frame width in pixels (≥ KERNEL_SIZE)
- HEIGHT, 32, frame height in pixels (≥ KERNEL_SIZE)
- KERNEL_SIZE, 3, window edge; only 3 supported
- ADDR_W, 10, image-memory address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- clk  in  1  single clock, rising edge
- rstb  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to process a frame; ignored unless idle
- buf_ready  in  1  line buffer can accept a pixel this cycle
- mem_rd_en  out  1  image-memory read strobe (combinational from state)
- mem_rd_addr  out  ADDR_W  raster read address, registered
- pix_valid  out  1  memory data valid; drives buffer read_valid
- win_valid  out  1  one-cycle pulse: a new 3x3 window is valid
- win_row  out  5  top row of the window, 0..HEIGHT-3
- win_col  out  5  left column of the window, 0..WIDTH-3
- res_addr  out  ADDR_W  result address = win_row*(WIDTH-2)+win_col
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of frame

## Operation
- The image memory has 1-cycle read latency. It holds its output while mem_rd_en is low.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. This clears the read counter, pixel counters and result counter.
  - RUN→DRAIN when the read at address WIDTH*HEIGHT-1 is issued.
  - DRAIN→DONE when the last pixel is accepted (pix_valid & buf_ready).
  - DONE→IDLE unconditionally after one cycle.
- mem_rd_en = (state==RUN) & (!pix_valid | buf_ready). mem_rd_addr increments on every issued read.
- pix_valid update, in priority order:
  - set on the edge after mem_rd_en;
  - otherwise cleared on the edge where buf_ready is high;
  - otherwise held. A stalled pixel stays valid, and no new read issues until it is accepted.
- Accept = pix_valid & buf_ready. On accept, the pixel counters (p_row, p_col) advance in raster order: p_col wraps at WIDTH-1 and p_row then increments.
- A window completes when the accepted pixel has p_row ≥ 2 and p_col ≥ 2.
  - win_valid pulses on the next cycle, with win_row = p_row-2 and win_col = p_col-2.
  - res_addr is a counter that increments after each win_valid; no multiplier is used.
- Pixels with p_col < 2 or p_row < 2 produce no window. Row-boundary wrap therefore never emits a window straddling two rows.
- Total per frame: WIDTH*HEIGHT reads and accepts, (WIDTH-2)*(HEIGHT-2) win_valid pulses, one done pulse.
- start during busy or DONE is ignored, with no queueing.
- Reset (any cycle, including mid-frame):
  - state = IDLE;
  - mem_rd_addr, win_row, win_col and res_addr = 0;
  - pix_valid, win_valid, busy and done = 0;
  - mem_rd_en = 0 because the state is IDLE.

## Timing
- Reference cycles are counted with start high in cycle 0.
- Unstalled flow:
  - RUN and busy from cycle 1.
  - Reads in cycles 1..WIDTH*HEIGHT.
  - pix_valid in cycles 2..WIDTH*HEIGHT+1.
- Latency from accept to win_valid: 1 cycle. This matches the buffer's registered column addresses, so window data is stable in the win_valid cycle.
- Default parameters, no stalls:
  - first win_valid in cycle 69 (pixel index 66 accepted in cycle 68);
  - last win_valid in cycle 1026;
  - done in cycle 1027, and busy falls in the same cycle;
  - start is accepted again from cycle 1028.
- Throughput: 1 pixel/cycle while buf_ready is high. Each cycle buf_ready is low adds exactly one cycle to all later events.

## Structure
- Shared package: FSM state encoding (IDLE, RUN, DRAIN, DONE) and the KERNEL_SIZE constant, shared with the buffer and the top-level control.
- Natural sub-module: conv_pos_counter. It holds the p_row/p_col raster counter with an enable and a wrap/last flag, and is instantiated once for pixel position.
- Read address and result address stay as plain counters in the top.

## Test plan
- Reset with buf_ready=1, pulse start once, read memory holding value = address -> 1024 reads at addresses 0..1023 in order; 900 win_valid pulses, the first (0,0) res_addr 0 in cycle 69, the last (29,29) res_addr 899; done in cycle 1027.
- buf_ready low for 5 cycles while pix_valid=1 at pixel 40 -> pix_valid held, mem_rd_en=0 for those 5 cycles, no pixel dropped or duplicated, done in cycle 1032.
- Assert start again in cycles 10 and 500 of a running frame -> ignored; exactly 900 windows and one done.
- Row wrap: track accepts of pixels (2,31) and (3,0)/(3,1) -> win_valid (0,29) after (2,31), none after (3,0)/(3,1), next (1,0) after (3,2).
- rstb low mid-frame at pixel 300, then released -> all outputs 0 and state IDLE; a subsequent start yields a full, correct frame from address 0.
- Random buf_ready (50%) for a full frame -> window count 900, res_addr sequence strictly 0..899, done exactly once.
